// File: rtl/audio_dsp_codec_if_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared constants and helpers for the WM8750 DSP-mode codec interface.
//   FRAME_LEN_48K / FRAME_LEN_32K : clk12 cycles per frame at 12.288 MHz
//   SAMPLE_W_DEFAULT              : default bits per channel
//   clog2()                       : counter / pointer width helper
// ---------------------------------------------------------------------------
package audio_pkg;

  localparam int FRAME_LEN_48K    = 256;
  localparam int FRAME_LEN_32K    = 384;
  localparam int SAMPLE_W_DEFAULT = 16;

  // Number of bits needed to count 0..value-1; never returns less than 1 so
  // that a degenerate parameter still yields a legal vector width.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/audio_dsp_codec_if_if.sv
// ---------------------------------------------------------------------------
// audio_dsp_codec_if_if
// Parallel-side bundle between the sound generator and the codec interface.
//   sample_valid/sample_ready : valid/ready handshake into the sample FIFO
//   sample_left/sample_right  : signed sample pair to play
//   underrun                  : 1-cycle pulse, frame started with empty FIFO
//   adc_valid                 : 1-cycle pulse, adc_left/adc_right refreshed
//   adc_left/adc_right        : captured ADC sample pair
// master = producer/consumer side, slave = codec interface side.
// ---------------------------------------------------------------------------
interface audio_dsp_codec_if_if import audio_pkg::*; #(
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT
);

  logic                       sample_valid;
  logic                       sample_ready;
  logic signed [SAMPLE_W-1:0] sample_left;
  logic signed [SAMPLE_W-1:0] sample_right;
  logic                       underrun;
  logic                       adc_valid;
  logic        [SAMPLE_W-1:0] adc_left;
  logic        [SAMPLE_W-1:0] adc_right;

  modport master (
    output sample_valid, sample_left, sample_right,
    input  sample_ready, underrun, adc_valid, adc_left, adc_right
  );

  modport slave (
    input  sample_valid, sample_left, sample_right,
    output sample_ready, underrun, adc_valid, adc_left, adc_right
  );

endinterface

// File: rtl/audio_sample_fifo.sv
// ---------------------------------------------------------------------------
// audio_sample_fifo
// Synchronous FIFO holding packed {left, right} sample pairs.
//   i_clk, i_rst_n    : clock, asynchronous active-low reset (empties FIFO)
//   i_push, i_data    : write request and data (ignored while full)
//   i_pop             : read request (ignored while empty)
//   o_data            : head entry, valid whenever !o_empty
//   o_full, o_empty   : occupancy flags
// ---------------------------------------------------------------------------
module audio_sample_fifo import audio_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int ADDR_W = clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_badDepth
    $error("audio_sample_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]  r_wptr;
  logic [ADDR_W:0]  r_rptr;
  logic             w_doPush;
  logic             w_doPop;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign o_empty  = (r_wptr == r_rptr);
  assign o_full   = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                    (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);
  assign o_data   = r_mem[r_rptr[ADDR_W-1:0]];
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  // Storage needs no reset: the pointers alone decide what is readable.
  always_ff @(posedge i_clk) begin
    if (w_doPush) begin
      r_mem[r_wptr[ADDR_W-1:0]] <= i_data;
    end
  end

  // Pointer update; reset collapses both pointers, which empties the FIFO.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_doPush) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_doPop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_dsp_codec_if.sv
// ---------------------------------------------------------------------------
// audio_dsp_codec_if
// WM8750 DSP-mode (mode B) stereo serial interface, MCLK = BCLK = clk12.
//   clk12, reset12_   : 12.288 MHz clock, asynchronous active-low reset
//   sample_bus        : sample FIFO handshake, underrun, ADC results
//   audio_mclk/bclk   : forwarded clk12
//   audio_daclrc/dat  : DAC frame sync and MSB-first serial data
//   audio_adclrc      : ADC frame sync (same timing as daclrc)
//   audio_adcdat      : ADC serial data from the codec
// ---------------------------------------------------------------------------
module audio_dsp_codec_if import audio_pkg::*; #(
  parameter int SAMPLE_W   = SAMPLE_W_DEFAULT,
  parameter int FRAME_LEN  = FRAME_LEN_48K,
  parameter int FIFO_DEPTH = 4,
  parameter bit MONO       = 1'b0
) (
  input  logic           clk12,
  input  logic           reset12_,
  audio_dsp_codec_if_if.slave sample_bus,
  output logic           audio_mclk,
  output logic           audio_bclk,
  output logic           audio_daclrc,
  output logic           audio_dacdat,
  output logic           audio_adclrc,
  input  logic           audio_adcdat
);

  localparam int WORD_W = 2 * SAMPLE_W;
  localparam int CNT_W  = clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] WORD_CNT  = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] LATCH_CNT = CNT_W'(WORD_W + 1);

  if ((SAMPLE_W < 8) || (SAMPLE_W > 24)) begin : g_badSampleW
    $error("audio_dsp_codec_if: SAMPLE_W must be within 8..24");
  end
  if (FRAME_LEN < (2 * SAMPLE_W + 2)) begin : g_badFrameLen
    $error("audio_dsp_codec_if: FRAME_LEN must be at least 2*SAMPLE_W+2");
  end

  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_word;
  logic [WORD_W-1:0] r_hold;
  logic [WORD_W-1:0] r_adcShift;
  logic [SAMPLE_W-1:0] r_adcLeft;
  logic [SAMPLE_W-1:0] r_adcRight;
  logic              r_adcValid;
  logic              r_underrun;
  logic              r_daclrc;
  logic              r_dacdat;
  logic              r_adclrc;

  logic              w_frameLoad;
  logic              w_fifoFull;
  logic              w_fifoEmpty;
  logic              w_push;
  logic              w_pop;
  logic [WORD_W-1:0] w_pushData;
  logic [WORD_W-1:0] w_fifoData;
  logic [WORD_W-1:0] w_loadWord;
  logic [WORD_W-1:0] w_wordShifted;
  logic              w_dacBit;
  logic              w_adcSample;
  logic              w_adcLatch;

  assign w_frameLoad = (r_cnt == LAST_CNT);
  assign w_push      = sample_bus.sample_valid && !w_fifoFull;
  assign w_pop       = w_frameLoad && !w_fifoEmpty;
  assign w_pushData  = {sample_bus.sample_left, sample_bus.sample_right};

  // In mono the right half of the stored pair is never transmitted.
  assign w_loadWord  = {w_fifoData[WORD_W-1 -: SAMPLE_W],
                        MONO ? w_fifoData[WORD_W-1 -: SAMPLE_W]
                             : w_fifoData[SAMPLE_W-1:0]};

  audio_sample_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk12),
    .i_rst_n (reset12_),
    .i_push  (w_push),
    .i_data  (w_pushData),
    .i_pop   (w_pop),
    .o_data  (w_fifoData),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty)
  );

  // Frame bit counter; everything else in the frame is decoded from it.
  always_ff @(posedge clk12 or negedge reset12_) begin
    if (!reset12_) begin
      r_cnt <= '0;
    end else if (w_frameLoad) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Frame load: take the next pair if there is one, otherwise repeat the
  // last pair so a starved producer holds the output level instead of
  // clicking, and flag the underrun on the first cycle of the new frame.
  always_ff @(posedge clk12 or negedge reset12_) begin
    if (!reset12_) begin
      r_word     <= '0;
      r_hold     <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_frameLoad && w_fifoEmpty;
      if (w_frameLoad) begin
        if (!w_fifoEmpty) begin
          r_word <= w_loadWord;
          r_hold <= w_loadWord;
        end else begin
          r_word <= r_hold;
        end
      end
    end
  end

  // Shifting by the bit count puts the current bit at the top, giving
  // MSB-first order without a separate shift register.
  assign w_wordShifted = r_word << r_cnt;
  assign w_dacBit      = (r_cnt < WORD_CNT) ? w_wordShifted[WORD_W-1] : 1'b0;

  // DAC pins are registered, so the sync pulse and the first data bit both
  // appear one cycle after cnt == 0 and line up with each other.
  always_ff @(posedge clk12 or negedge reset12_) begin
    if (!reset12_) begin
      r_daclrc <= 1'b0;
      r_dacdat <= 1'b0;
      r_adclrc <= 1'b0;
    end else begin
      r_daclrc <= (r_cnt == '0);
      r_dacdat <= w_dacBit;
      r_adclrc <= (r_cnt == '0);
    end
  end

  // The codec returns its MSB in the cycle our sync is visible (cnt == 1),
  // so bits are sampled while cnt runs 1..2W and latched at 2W+1.
  assign w_adcSample = (r_cnt != '0) && (r_cnt <= WORD_CNT);
  assign w_adcLatch  = (r_cnt == LATCH_CNT);

  // ADC deserialiser and parallel result registers.
  always_ff @(posedge clk12 or negedge reset12_) begin
    if (!reset12_) begin
      r_adcShift <= '0;
      r_adcLeft  <= '0;
      r_adcRight <= '0;
      r_adcValid <= 1'b0;
    end else begin
      r_adcValid <= w_adcLatch;
      if (w_adcSample) begin
        r_adcShift <= {r_adcShift[WORD_W-2:0], audio_adcdat};
      end
      if (w_adcLatch) begin
        r_adcLeft  <= r_adcShift[WORD_W-1 -: SAMPLE_W];
        r_adcRight <= r_adcShift[SAMPLE_W-1:0];
      end
    end
  end

  assign sample_bus.sample_ready = !w_fifoFull;
  assign sample_bus.underrun     = r_underrun;
  assign sample_bus.adc_valid    = r_adcValid;
  assign sample_bus.adc_left     = r_adcLeft;
  assign sample_bus.adc_right    = r_adcRight;

  assign audio_mclk   = clk12;
  assign audio_bclk   = clk12;
  assign audio_daclrc = r_daclrc;
  assign audio_dacdat = r_dacdat;
  assign audio_adclrc = r_adclrc;

endmodule

// File: tb/tb_audio_dsp_codec_if.sv
// ---------------------------------------------------------------------------
// tb_audio_dsp_codec_if
// Directed bench for audio_dsp_codec_if: one stereo instance (W=16,
// FRAME_LEN=256, depth 4) and one mono instance sharing clock and reset.
// ---------------------------------------------------------------------------
module tb_audio_dsp_codec_if;
  import audio_pkg::*;

  localparam int W  = 16;
  localparam int FL = 256;

  logic clk12 = 1'b0;
  logic reset12_;
  logic adcdat;
  logic mclk1, bclk1, daclrc1, dacdat1, adclrc1;
  logic mclk2, bclk2, daclrc2, dacdat2, adclrc2;

  int testsRun    = 0;
  int testsFailed = 0;
  int expCnt      = 0;

  logic [31:0] pairs [5] = '{32'h1111_8888, 32'h2222_7777, 32'h3333_6666,
                             32'h4444_5555, 32'hDEAD_BEEF};

  audio_dsp_codec_if_if #(.SAMPLE_W(W)) bus1 ();
  audio_dsp_codec_if_if #(.SAMPLE_W(W)) bus2 ();

  audio_dsp_codec_if #(
    .SAMPLE_W(W), .FRAME_LEN(FL), .FIFO_DEPTH(4), .MONO(1'b0)
  ) dut (
    .clk12(clk12), .reset12_(reset12_), .sample_bus(bus1),
    .audio_mclk(mclk1), .audio_bclk(bclk1), .audio_daclrc(daclrc1),
    .audio_dacdat(dacdat1), .audio_adclrc(adclrc1), .audio_adcdat(adcdat)
  );

  audio_dsp_codec_if #(
    .SAMPLE_W(W), .FRAME_LEN(FL), .FIFO_DEPTH(4), .MONO(1'b1)
  ) dutMono (
    .clk12(clk12), .reset12_(reset12_), .sample_bus(bus2),
    .audio_mclk(mclk2), .audio_bclk(bclk2), .audio_daclrc(daclrc2),
    .audio_dacdat(dacdat2), .audio_adclrc(adclrc2), .audio_adcdat(adcdat)
  );

  always #5 clk12 = ~clk12;

  // Expected frame position: the count the design should hold this cycle.
  always @(posedge clk12 or negedge reset12_) begin
    if (!reset12_) expCnt <= 0;
    else           expCnt <= (expCnt == FL - 1) ? 0 : expCnt + 1;
  end

  // Advance to the falling edge of the cycle whose expected count is target.
  task automatic waitCnt(input int target);
    int guard;
    guard = 0;
    do begin
      @(negedge clk12);
      guard++;
    end while ((expCnt != target) && (guard < 2 * FL));
    if (expCnt != target) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL wait_cnt: reached %0d, wanted %0d", expCnt, target);
    end
  endtask

  task automatic test_reset();
    reset12_ = 1'b0;
    adcdat   = 1'b0;
    bus1.sample_valid = 1'b0; bus1.sample_left = '0; bus1.sample_right = '0;
    bus2.sample_valid = 1'b0; bus2.sample_left = '0; bus2.sample_right = '0;
    repeat (3) @(negedge clk12);
    testsRun++;
    if ({daclrc1, dacdat1, adclrc1, bus1.underrun, bus1.adc_valid} !== 5'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_pins: got %b expected 00000",
               {daclrc1, dacdat1, adclrc1, bus1.underrun, bus1.adc_valid});
    end
    testsRun++;
    if (bus1.adc_left !== 16'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_adc_left: got %h expected 0000", bus1.adc_left);
    end
    testsRun++;
    if (bus1.adc_right !== 16'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_adc_right: got %h expected 0000", bus1.adc_right);
    end
    testsRun++;
    if (bus1.sample_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_ready: got %b expected 1", bus1.sample_ready);
    end
    testsRun++;
    if ({mclk1, bclk1} !== {clk12, clk12}) begin
      testsFailed++;
      $display("[TB] FAIL reset_clocks: got %b expected %b", {mclk1, bclk1}, {clk12, clk12});
    end
    reset12_ = 1'b1;
  endtask

  task automatic test_idle_frame();
    waitCnt(0);
    for (int n = 0; n < FL; n++) begin
      int c;
      logic [4:0] expPins;
      c = expCnt;
      expPins = {c == 1, 1'b0, c == 1, c == 0, c == 34};
      testsRun++;
      if ({daclrc1, dacdat1, adclrc1, bus1.underrun, bus1.adc_valid} !== expPins) begin
        testsFailed++;
        $display("[TB] FAIL idle_pins cnt=%0d: got %b expected %b", c,
                 {daclrc1, dacdat1, adclrc1, bus1.underrun, bus1.adc_valid}, expPins);
      end
      @(negedge clk12);
    end
  endtask

  task automatic test_push_frame();
    logic [31:0] expWord;
    expWord = 32'hA5C30F01;
    waitCnt(100);
    bus1.sample_valid = 1'b1; bus1.sample_left = 16'hA5C3; bus1.sample_right = 16'h0F01;
    @(negedge clk12);
    bus1.sample_valid = 1'b0;
    waitCnt(0);
    for (int n = 0; n < 2 * FL; n++) begin
      int c;
      logic expD;
      logic [4:0] expPins;
      c = expCnt;
      expD = (c >= 1 && c <= 32) ? expWord[32 - c] : 1'b0;
      expPins = {c == 1, expD, c == 1, (c == 0) && (n >= FL), c == 34};
      testsRun++;
      if ({daclrc1, dacdat1, adclrc1, bus1.underrun, bus1.adc_valid} !== expPins) begin
        testsFailed++;
        $display("[TB] FAIL push_frame pins frame=%0d cnt=%0d: got %b expected %b", n / FL, c,
                 {daclrc1, dacdat1, adclrc1, bus1.underrun, bus1.adc_valid}, expPins);
      end
      @(negedge clk12);
    end
  endtask

  task automatic test_back_to_back();
    int i;
    int guard;
    int fIdx;
    bit done;
    waitCnt(250);
    i = 0;
    guard = 0;
    while ((i < 5) && (guard < 20)) begin
      logic expReady;
      bus1.sample_valid = 1'b1;
      bus1.sample_left  = pairs[i][31:16];
      bus1.sample_right = pairs[i][15:0];
      expReady = !((expCnt == 254) || (expCnt == 255));
      testsRun++;
      if (bus1.sample_ready !== expReady) begin
        testsFailed++;
        $display("[TB] FAIL b2b_ready cnt=%0d: got %b expected %b", expCnt, bus1.sample_ready, expReady);
      end
      if (expReady) i++;
      @(negedge clk12);
      guard++;
    end
    bus1.sample_valid = 1'b0;
    fIdx = 0;
    done = 1'b0;
    guard = 0;
    while (!done && (guard < 7 * FL)) begin
      int c;
      logic expD;
      logic [31:0] curWord;
      c = expCnt;
      if (c == 0) fIdx++;
      if (fIdx == 5) begin
        testsRun++;
        if (bus1.underrun !== 1'b1) begin
          testsFailed++;
          $display("[TB] FAIL b2b_final_underrun: got %b expected 1", bus1.underrun);
        end
        done = 1'b1;
      end else begin
        curWord = pairs[fIdx];
        expD = (c >= 1 && c <= 32) ? curWord[32 - c] : 1'b0;
        testsRun++;
        if ({daclrc1, dacdat1, bus1.underrun} !== {c == 1, expD, 1'b0}) begin
          testsFailed++;
          $display("[TB] FAIL b2b_tx pair=%0d cnt=%0d: got %b expected %b", fIdx, c,
                   {daclrc1, dacdat1, bus1.underrun}, {c == 1, expD, 1'b0});
        end
        @(negedge clk12);
        guard++;
      end
    end
    if (!done) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL b2b_timeout: got frames %0d expected 5", fIdx);
    end
  endtask

  task automatic test_mono();
    logic [31:0] expWord;
    expWord = 32'h12341234;
    waitCnt(100);
    bus2.sample_valid = 1'b1; bus2.sample_left = 16'h1234; bus2.sample_right = 16'hFFFF;
    @(negedge clk12);
    bus2.sample_valid = 1'b0;
    waitCnt(0);
    for (int n = 0; n < 40; n++) begin
      int c;
      logic expD;
      c = expCnt;
      expD = (c >= 1 && c <= 32) ? expWord[32 - c] : 1'b0;
      testsRun++;
      if ({daclrc2, dacdat2, adclrc2, bus2.underrun} !== {c == 1, expD, c == 1, 1'b0}) begin
        testsFailed++;
        $display("[TB] FAIL mono_tx cnt=%0d: got %b expected %b", c,
                 {daclrc2, dacdat2, adclrc2, bus2.underrun}, {c == 1, expD, c == 1, 1'b0});
      end
      @(negedge clk12);
    end
  endtask

  task automatic test_adc();
    logic [31:0] pattern;
    pattern = 32'h80017FFE;
    waitCnt(0);
    for (int n = 0; n < 41; n++) begin
      int c;
      c = expCnt;
      if (c == 33) begin
        testsRun++;
        if ({bus1.adc_valid, bus1.adc_left, bus1.adc_right} !== {1'b0, 32'h0}) begin
          testsFailed++;
          $display("[TB] FAIL adc_before: got %b %h %h expected 0 0000 0000",
                   bus1.adc_valid, bus1.adc_left, bus1.adc_right);
        end
      end
      if (c == 34) begin
        testsRun++;
        if ({bus1.adc_valid, bus1.adc_left, bus1.adc_right} !== {1'b1, 16'h8001, 16'h7FFE}) begin
          testsFailed++;
          $display("[TB] FAIL adc_capture: got %b %h %h expected 1 8001 7ffe",
                   bus1.adc_valid, bus1.adc_left, bus1.adc_right);
        end
      end
      if (c == 40) begin
        testsRun++;
        if ({bus1.adc_valid, bus1.adc_left, bus1.adc_right} !== {1'b0, 16'h8001, 16'h7FFE}) begin
          testsFailed++;
          $display("[TB] FAIL adc_hold: got %b %h %h expected 0 8001 7ffe",
                   bus1.adc_valid, bus1.adc_left, bus1.adc_right);
        end
      end
      adcdat = (c >= 1 && c <= 32) ? pattern[32 - c] : 1'b0;
      @(negedge clk12);
    end
    adcdat = 1'b0;
  endtask

  task automatic test_reset_midframe();
    waitCnt(50);
    bus1.sample_valid = 1'b1; bus1.sample_left = 16'hFFFF; bus1.sample_right = 16'h0000;
    @(negedge clk12);
    bus1.sample_valid = 1'b0;
    waitCnt(5);
    bus1.sample_valid = 1'b1; bus1.sample_left = 16'h5A5A; bus1.sample_right = 16'hA5A5;
    @(negedge clk12);
    bus1.sample_valid = 1'b0;
    waitCnt(10);
    testsRun++;
    if ({dacdat1, bus1.adc_left} !== {1'b1, 16'h8001}) begin
      testsFailed++;
      $display("[TB] FAIL midframe_pre: got %b %h expected 1 8001", dacdat1, bus1.adc_left);
    end
    reset12_ = 1'b0;
    #1;
    testsRun++;
    if ({daclrc1, dacdat1, adclrc1, bus1.underrun, bus1.adc_valid,
         bus1.adc_left, bus1.adc_right, bus1.sample_ready} !== {5'b0, 32'h0, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL midframe_async: got %b %h %h %b expected 00000 0000 0000 1",
               {daclrc1, dacdat1, adclrc1, bus1.underrun, bus1.adc_valid},
               bus1.adc_left, bus1.adc_right, bus1.sample_ready);
    end
    repeat (3) @(negedge clk12);
    reset12_ = 1'b1;
    #1;
    testsRun++;
    if ({daclrc1, dacdat1, adclrc1} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL release_cnt0: got %b expected 000", {daclrc1, dacdat1, adclrc1});
    end
    @(negedge clk12);
    testsRun++;
    if ({daclrc1, dacdat1, adclrc1} !== 3'b101) begin
      testsFailed++;
      $display("[TB] FAIL release_sync: got %b expected 101", {daclrc1, dacdat1, adclrc1});
    end
    waitCnt(0);
    for (int n = 0; n < 40; n++) begin
      int c;
      c = expCnt;
      testsRun++;
      if ({daclrc1, dacdat1, adclrc1, bus1.underrun} !== {c == 1, 1'b0, c == 1, c == 0}) begin
        testsFailed++;
        $display("[TB] FAIL release_frame cnt=%0d: got %b expected %b", c,
                 {daclrc1, dacdat1, adclrc1, bus1.underrun}, {c == 1, 1'b0, c == 1, c == 0});
      end
      @(negedge clk12);
    end
  endtask

  initial begin
    test_reset();
    test_idle_frame();
    test_push_frame();
    test_back_to_back();
    test_mono();
    test_adc();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/audio_dsp_codec_if.md
Name: audio_dsp_codec_if

Overview:
- Parametrised WM8750 DSP-mode (mode B, codec master-clocked by our MCLK=BCLK=clk12) stereo serial interface.
- Successor to the fixed 16-bit mono-duplicating DAC path. Adds:
  - configurable sample width and frame length;
  - independent L/R samples fed through a valid/ready sample FIFO, with underrun reporting;
  - ADC capture of the returning serial stream into parallel L/R words.
- Sits between the sound generator and the codec pins.

Parameters:
- SAMPLE_W, 16, bits per channel; 8..24.
- FRAME_LEN, 256, clk12 cycles per frame (256 → 48 kHz at 12.288 MHz); must be ≥ 2*SAMPLE_W+2.
- FIFO_DEPTH, 4, sample-pair FIFO entries; power of two, ≥ 2.
- MONO, 0, 1 = sample_left is sent on both channels and sample_right is ignored.

Ports:
- clk12  in  1  12.288 MHz clock.
- reset12_  in  1  reset, asynchronous, active-low.
- sample_valid  in  1  producer has a sample pair.
- sample_ready  out  1  FIFO not full.
- sample_left  in  SAMPLE_W  left sample, signed two's complement.
- sample_right  in  SAMPLE_W  right sample, signed two's complement.
- underrun  out  1  1-cycle pulse: frame started with an empty FIFO.
- audio_mclk  out  1  = clk12.
- audio_bclk  out  1  = clk12.
- audio_daclrc  out  1  DAC frame sync.
- audio_dacdat  out  1  DAC serial data.
- audio_adclrc  out  1  ADC frame sync.
- audio_adcdat  in  1  ADC serial data.
- adc_valid  out  1  1-cycle pulse: adc_left/adc_right updated.
- adc_left  out  SAMPLE_W  captured left.
- adc_right  out  SAMPLE_W  captured right.

Behaviour:
- Reset values:
  - all registered outputs 0 (daclrc, dacdat, adclrc, underrun, adc_valid, adc_left, adc_right);
  - bit counter 0; FIFO emptied; hold register 0.
  - Reset takes effect immediately (async), including mid-frame; on release the frame restarts at count 0.
- Bit counter cnt: 0..FRAME_LEN-1, +1 per cycle, wraps to 0.
- FIFO push: occurs when sample_valid & sample_ready.
  - sample_ready = !full, combinational, so it is 1 during and after reset.
  - Simultaneous push and pop on a full FIFO: push is refused (ready already low); ready rises the cycle after the pop.
- Frame load (cnt == FRAME_LEN-1):
  - FIFO not empty: pop, and set shift word = {L, MONO ? L : R}; the popped pair is also stored in the hold register.
  - FIFO empty: shift word = hold register (last pair repeated), and underrun is asserted on the next cycle for one cycle.
- DAC output (registered, from cnt):
  - daclrc_nxt = (cnt == 0).
  - dacdat_nxt = word[2W-1-cnt] for cnt < 2W, else 0.
  - The MSB of left is on the pins in the same cycle daclrc is high; right follows immediately; data is MSB-first throughout.
- adclrc is identical to daclrc.
- ADC capture:
  - Bit k (k = 0..2W-1, MSB of left first) is sampled from audio_adcdat at the edge ending the cycle where cnt == k+1.
  - When cnt == 2W+1: adc_left/adc_right are updated from the capture shift register, and adc_valid pulses 1 cycle later, aligned with the new values.
  - Captured values hold between frames.
- FRAME_LEN violating the constraint is an elaboration error (generate-time check).

Decomposition:
- Package audio_pkg: frame-length-for-rate constants (48 kHz = 256, 32 kHz = 384 at 12.288 MHz), SAMPLE_W default, and a helper function clog2 for counter widths.
- Sub-module audio_sample_fifo: synchronous FIFO, width 2*SAMPLE_W, depth FIFO_DEPTH, with push/pop/full/empty and async active-low reset.
- Framing, DAC serialiser and ADC deserialiser stay in the top module.

Test Plan:
- Reset, no pushes, W=16, FRAME_LEN=256 → daclrc and adclrc high 1 cycle every 256 cycles; dacdat constant 0; underrun pulses once per frame.
- Push L=16'hA5C3, R=16'h0F01 → next frame dacdat serialises 32'hA5C30F01 MSB-first starting on the daclrc-high cycle, then 224 zeros. Following frame with no push repeats A5C30F01 and underrun pulses.
- Push 5 pairs back-to-back with FIFO_DEPTH=4 → sample_ready low after the 4th accept; the 5th is accepted the cycle after the first frame pop; the pairs are transmitted in order, one per frame.
- Drive audio_adcdat with 32'h80017FFE, bit k in the cycle cnt == k+1 → adc_left=16'h8001, adc_right=16'h7FFE; adc_valid pulses 1 cycle after cnt == 33.
- Pull reset12_ low while cnt == 10 mid-frame → all outputs 0 in the same cycle (async); FIFO empty; after release daclrc pulses at cnt 0 with data 0.
- MONO=1, push L=16'h1234, R=16'hFFFF → dacdat serialises 32'h12341234.
